// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I multi-cycle control unit.
//   - opcode constants for the nine RV32I instruction classes
//   - alu_control, imm_sel, WBsel and trap_cause encodings
//   - instruction-class and controller-state enums
//   - alu_from_funct3: ALU operation for OP / OP-IMM given funct3 and the alternate bit
package riscv_pkg;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // alu_control encodings
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd15;

    // imm_sel encodings
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // WBsel encodings
    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // trap_cause encodings
    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    typedef enum logic [3:0] {
        C_LUI,
        C_AUIPC,
        C_JAL,
        C_JALR,
        C_BRANCH,
        C_LOAD,
        C_STORE,
        C_OP_IMM,
        C_OP,
        C_ILLEGAL
    } instr_class_t;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    // alt selects SUB over ADD (funct3=000) and SRA over SRL (funct3=101).
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I instruction decoder.
// Ports:
//   instr        in  32  IR contents
//   iclass       out     instruction class (C_ILLEGAL for unknown opcodes)
//   alu_control  out  4  ALU operation for the class
//   imm_sel      out  3  immediate format for the class
//   illegal      out  1  opcode is not one of the nine RV32I classes
module instr_decoder
    import riscv_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t iclass,
    output logic [3:0]   alu_control,
    output logic [2:0]   imm_sel,
    output logic         illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign alt    = instr[30];

    // Register and immediate fields are consumed by the datapath, not here.
    logic unused_fields;
    assign unused_fields = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        iclass      = C_ILLEGAL;
        alu_control = ALU_ADD;
        imm_sel     = IMM_I;
        illegal     = 1'b0;
        case (opcode)
            OPC_LUI: begin
                iclass      = C_LUI;
                alu_control = ALU_LUI;
                imm_sel     = IMM_U;
            end
            OPC_AUIPC: begin
                iclass  = C_AUIPC;
                imm_sel = IMM_U;
            end
            OPC_JAL: begin
                iclass  = C_JAL;
                imm_sel = IMM_J;
            end
            OPC_JALR:   iclass = C_JALR;
            OPC_BRANCH: begin
                iclass  = C_BRANCH;
                imm_sel = IMM_B;
            end
            OPC_LOAD:   iclass = C_LOAD;
            OPC_STORE: begin
                iclass  = C_STORE;
                imm_sel = IMM_S;
            end
            OPC_OP_IMM: begin
                // instr[30] is part of the immediate except for SRAI.
                iclass      = C_OP_IMM;
                alu_control = alu_from_funct3(funct3, (funct3 == 3'b101) && alt);
            end
            OPC_OP: begin
                iclass      = C_OP;
                alu_control = alu_from_funct3(funct3, alt);
            end
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing over a shared
// valid/ready memory port, illegal-opcode and memory-timeout traps, retired-instruction count.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   instr                 IR contents held by the datapath
//   BrEq, BrLt            branch comparator results
//   mem_ready             memory completes the current request this cycle
//   mem_req, MemRW        memory request valid, 1 = store
//   iaddr_sel             memory address from PC (1) or ALU (0)
//   ir_wen, pc_wen        IR / PC load enables
//   PCsel                 0 = PC+4, 1 = ALU result
//   RegWEn, WBsel         register write enable and write-back source
//   imm_sel, Asel, Bsel   immediate format and ALU operand selects
//   BrUn, alu_control     unsigned compare, ALU operation
//   trap, trap_cause      sticky error flag and its cause
//   instret               retired-instruction counter (wraps)
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic                 BrEq,
    input  logic                 BrLt,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 MemRW,
    output logic                 iaddr_sel,
    output logic                 ir_wen,
    output logic                 pc_wen,
    output logic                 PCsel,
    output logic                 RegWEn,
    output logic [2:0]           imm_sel,
    output logic                 Asel,
    output logic                 Bsel,
    output logic                 BrUn,
    output logic [1:0]           WBsel,
    output logic [3:0]           alu_control,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [CNT_WIDTH-1:0] instret
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    // Value of the wait counter on the last cycle allowed to go without mem_ready.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [1:0]           cause_q, cause_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;

    instr_class_t dec_class;
    logic [3:0]   dec_alu;
    logic [2:0]   dec_imm;
    logic         dec_illegal;

    instr_decoder u_decoder (
        .instr       (instr),
        .iclass      (dec_class),
        .alu_control (dec_alu),
        .imm_sel     (dec_imm),
        .illegal     (dec_illegal)
    );

    logic [2:0] funct3;
    logic       use_pc_a, use_imm_b, is_load, is_store, is_jump, is_branch;
    logic       br_taken, timeout_hit, retire;

    assign funct3    = instr[14:12];
    assign use_pc_a  = (dec_class == C_AUIPC) || (dec_class == C_JAL) || (dec_class == C_BRANCH);
    assign use_imm_b = (dec_class != C_OP);
    assign is_load   = (dec_class == C_LOAD);
    assign is_store  = (dec_class == C_STORE);
    assign is_jump   = (dec_class == C_JAL) || (dec_class == C_JALR);
    assign is_branch = (dec_class == C_BRANCH);

    // Undefined funct3 (010, 011) is never taken.
    always_comb begin
        case (funct3)
            3'b000:         br_taken = BrEq;
            3'b001:         br_taken = !BrEq;
            3'b100, 3'b110: br_taken = BrLt;
            3'b101, 3'b111: br_taken = !BrLt;
            default:        br_taken = 1'b0;
        endcase
    end

    // mem_ready on the limit cycle still completes the request.
    assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_q == WAIT_LAST);

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        retire      = 1'b0;
        mem_req     = 1'b0;
        MemRW       = 1'b0;
        iaddr_sel   = 1'b0;
        ir_wen      = 1'b0;
        pc_wen      = 1'b0;
        PCsel       = 1'b0;
        RegWEn      = 1'b0;
        imm_sel     = IMM_I;
        Asel        = 1'b0;
        Bsel        = 1'b0;
        BrUn        = 1'b0;
        WBsel       = WB_MEM;
        alu_control = ALU_ADD;
        trap        = 1'b0;
        trap_cause  = CAUSE_NONE;

        unique case (state_q)
            S_RESET: state_d = S_FETCH;

            S_FETCH: begin
                mem_req   = 1'b1;
                iaddr_sel = 1'b1;
                if (mem_ready) begin
                    ir_wen  = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = S_TRAP;
                end
            end

            S_DECODE: begin
                if (dec_illegal) begin
                    cause_d = CAUSE_ILLEGAL;
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                imm_sel     = dec_imm;
                Asel        = use_pc_a;
                Bsel        = use_imm_b;
                alu_control = dec_alu;
                if (is_branch) begin
                    BrUn    = (funct3[2:1] == 2'b11);
                    PCsel   = br_taken;
                    pc_wen  = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                // Address comes from the ALU, so its controls stay put.
                mem_req     = 1'b1;
                MemRW       = is_store;
                imm_sel     = dec_imm;
                Asel        = use_pc_a;
                Bsel        = use_imm_b;
                alu_control = dec_alu;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_wen  = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = S_TRAP;
                end
            end

            S_WB: begin
                RegWEn  = 1'b1;
                pc_wen  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
                if (is_load) begin
                    WBsel = WB_MEM;
                end else if (is_jump) begin
                    // Jump target is computed by the ALU while PC+4 is written back.
                    WBsel       = WB_PC4;
                    PCsel       = 1'b1;
                    imm_sel     = dec_imm;
                    Asel        = use_pc_a;
                    Bsel        = use_imm_b;
                    alu_control = dec_alu;
                end else begin
                    WBsel = WB_ALU;
                end
            end

            S_TRAP: begin
                trap       = 1'b1;
                trap_cause = cause_q;
            end

            default: state_d = S_RESET;
        endcase
    end

    // Any cycle that is not an unanswered request clears the counter, which also
    // covers entry into S_FETCH / S_MEM.
    assign wait_d    = (mem_req && !mem_ready) ? wait_q + 1'b1 : '0;
    assign instret_d = retire ? instret_q + CNT_WIDTH'(1) : instret_q;
    assign instret   = instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            wait_q    <= '0;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

endmodule
